// File: rtl/div_issue_tracker.sv
// div_issue_tracker: issue/retire bookkeeping around an external unsigned
// pipelined divider. Converts signed operands to magnitudes on the way in,
// carries a per-op tag down a DIV_LATENCY-deep shift register, and fixes up
// sign, divide-by-zero and overflow on the way out.
// Optional feature macro: DIV_HAZARD_CHECK_EN (RAW check of new sources
// against in-flight destination tags).
module div_issue_tracker #(
  parameter int unsigned DIV_LATENCY = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1_idx,
  input  logic [4:0]  i_rs2_idx,
  input  logic        i_flush,
  output logic [31:0] o_dividend,
  output logic [31:0] o_divisor,
  input  logic [31:0] i_div_quotient,
  input  logic [31:0] i_div_remainder,
  output logic        o_valid,
  output logic [4:0]  o_rd,
  output logic [31:0] o_result,
  output logic [3:0]  o_inflight,
  output logic        o_hazard
);

  localparam int unsigned L = DIV_LATENCY;

  // op[0] clear selects the signed variants (DIV, REM)
  logic w_signed;
  logic w_rs1_neg;
  logic w_rs2_neg;
  logic w_div_zero;
  logic w_accept;
  logic w_retire;

  assign w_signed   = ~i_op[0];
  assign w_rs1_neg  = w_signed & i_rs1_data[31];
  assign w_rs2_neg  = w_signed & i_rs2_data[31];
  assign w_div_zero = (i_rs2_data == '0);
  assign w_accept   = i_valid & ~i_flush;

  // Two's-complement magnitude; 0x80000000 maps onto itself, i.e. 2^31 unsigned
  assign o_dividend = w_rs1_neg ? (32'd0 - i_rs1_data) : i_rs1_data;
  assign o_divisor  = w_rs2_neg ? (32'd0 - i_rs2_data) : i_rs2_data;

  // Tag pipeline, stage 1 is youngest, stage L lines up with divider output
  logic        r_valid [1:L];
  logic [1:0]  r_op    [1:L];
  logic [4:0]  r_rd    [1:L];
  logic        r_qneg  [1:L];
  logic        r_rneg  [1:L];
  logic        r_dz    [1:L];
  logic [31:0] r_rs1   [1:L];
  logic [3:0]  r_inflight;

  // Shift every cycle; flush wipes all valid bits including the new entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i <= L; i++) begin
        r_valid[i] <= 1'b0;
        r_op[i]    <= '0;
        r_rd[i]    <= '0;
        r_qneg[i]  <= 1'b0;
        r_rneg[i]  <= 1'b0;
        r_dz[i]    <= 1'b0;
        r_rs1[i]   <= '0;
      end
    end else begin
      r_valid[1] <= w_accept;
      r_op[1]    <= i_op;
      r_rd[1]    <= i_rd;
      r_qneg[1]  <= w_signed & (i_rs1_data[31] ^ i_rs2_data[31]) & ~w_div_zero;
      r_rneg[1]  <= w_rs1_neg;
      r_dz[1]    <= w_div_zero;
      r_rs1[1]   <= i_rs1_data;
      for (int unsigned i = 2; i <= L; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_op[i]    <= r_op[i-1];
        r_rd[i]    <= r_rd[i-1];
        r_qneg[i]  <= r_qneg[i-1];
        r_rneg[i]  <= r_rneg[i-1];
        r_dz[i]    <= r_dz[i-1];
        r_rs1[i]   <= r_rs1[i-1];
      end
      if (i_flush) begin
        for (int unsigned i = 1; i <= L; i++) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign w_retire = r_valid[L];

  // Occupancy count: accept and retire in the same cycle cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else if (i_flush) begin
      r_inflight <= '0;
    end else begin
      case ({w_accept, w_retire})
        2'b10:   r_inflight <= r_inflight + 4'd1;
        2'b01:   r_inflight <= r_inflight - 4'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign o_inflight = r_inflight;

  // Result fix-up at stage L; signed overflow (MIN / -1) falls out naturally
  // since 2^31 / 1 = 0x80000000 with both signs negative (no negate).
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  // Select quotient or remainder, apply sign / divide-by-zero overrides
  always_comb begin
    w_quot = r_qneg[L] ? (32'd0 - i_div_quotient)  : i_div_quotient;
    w_rem  = r_rneg[L] ? (32'd0 - i_div_remainder) : i_div_remainder;
    if (r_dz[L]) begin
      w_quot = '1;
      w_rem  = r_rs1[L];
    end
    o_valid  = r_valid[L];
    o_rd     = '0;
    o_result = '0;
    if (r_valid[L]) begin
      o_rd     = r_rd[L];
      o_result = r_op[L][1] ? w_rem : w_quot;
    end
  end

`ifdef DIV_HAZARD_CHECK_EN
  // Compare new sources against younger in-flight destinations; stage L is
  // retiring this cycle and forwards normally, so it is excluded.
  always_comb begin
    o_hazard = 1'b0;
    if (i_valid) begin
      for (int unsigned i = 1; i < L; i++) begin
        if (r_valid[i] &&
            (((i_rs1_idx != '0) && (i_rs1_idx == r_rd[i])) ||
             ((i_rs2_idx != '0) && (i_rs2_idx == r_rd[i])))) begin
          o_hazard = 1'b1;
        end
      end
    end
  end
`else
  logic w_unused_idx;
  assign w_unused_idx = ^{i_rs1_idx, i_rs2_idx};
  assign o_hazard     = 1'b0;
`endif

endmodule

// File: tb/tb_div_issue_tracker.sv
// Scoreboard bench for div_issue_tracker: an ideal pipelined divider model
// feeds the DUT, a reference model computes RISC-V style div/rem results from
// signed/unsigned arithmetic, and a negedge monitor checks retirements.
module tb_div_issue_tracker;

  localparam int unsigned L = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [1:0]  i_op;
  logic [31:0] i_rs1_data, i_rs2_data;
  logic [4:0]  i_rd, i_rs1_idx, i_rs2_idx;
  logic        i_flush;
  logic [31:0] o_dividend, o_divisor;
  logic [31:0] i_div_quotient, i_div_remainder;
  logic        o_valid;
  logic [4:0]  o_rd;
  logic [31:0] o_result;
  logic [3:0]  o_inflight;
  logic        o_hazard;

  div_issue_tracker #(.DIV_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_op(i_op),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_rd(i_rd),
    .i_rs1_idx(i_rs1_idx), .i_rs2_idx(i_rs2_idx), .i_flush(i_flush),
    .o_dividend(o_dividend), .o_divisor(o_divisor),
    .i_div_quotient(i_div_quotient), .i_div_remainder(i_div_remainder),
    .o_valid(o_valid), .o_rd(o_rd), .o_result(o_result),
    .o_inflight(o_inflight), .o_hazard(o_hazard)
  );

  always #5 clk = ~clk;

  // Attached divider: unsigned, L cycles, junk on divide-by-zero
  logic [63:0] pipe [0:L-1];
  logic [31:0] dv_n, dv_d;
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= {o_dividend, o_divisor};
  end
  assign {dv_n, dv_d}    = pipe[L-1];
  assign i_div_quotient  = (dv_d == 0) ? 32'h0BAD0BAD : dv_n / dv_d;
  assign i_div_remainder = (dv_d == 0) ? 32'h0DEAD00D : dv_n % dv_d;

  typedef struct { logic [4:0] rd; logic [31:0] res; } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa, sb_;
    sa = int'(a);
    sb_ = int'(b);
    case (op)
      2'b00: if (b == 0) return 32'hFFFFFFFF;
             else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
             else return 32'(sa / sb_);
      2'b01: return (b == 0) ? 32'hFFFFFFFF : a / b;
      2'b10: if (b == 0) return a;
             else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
             else return 32'(sa % sb_);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] mag(input logic sgn, input logic [31:0] x);
    return (sgn && x[31]) ? 32'(0 - x) : x;
  endfunction

  // Monitor: every retirement must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", {31'd0, o_valid}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ret_rd", {27'd0, o_rd}, {27'd0, e.rd});
          chk("ret_result", o_result, e.res);
        end
      end else begin
        chk("idle_rd_zero", {27'd0, o_rd}, 32'd0);
        chk("idle_result_zero", o_result, 32'd0);
      end
    end
  end

  // One cycle of stimulus; a flush driven last cycle empties the scoreboard
  // at the edge where it takes effect.
  task automatic issue(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [4:0] s1,
                       input logic [4:0] s2, input logic fl, input logic [32:0] force_exp);
    exp_t e;
    @(posedge clk);
    if (i_flush) sb.delete();
    #1;
    i_valid = v; i_op = op; i_rs1_data = a; i_rs2_data = b; i_rd = rd;
    i_rs1_idx = s1; i_rs2_idx = s2; i_flush = fl;
    #1;
    if (v) begin
      chk("dividend_mag", o_dividend, mag(~op[0], a));
      chk("divisor_mag", o_divisor, mag(~op[0], b));
    end
    if (v && !fl) begin
      e.rd  = rd;
      e.res = force_exp[32] ? force_exp[31:0] : ref_result(op, a, b);
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    issue(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 33'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 4 * L) begin
      idle();
      n++;
    end
    chk("drain_timeout", sb.size(), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom % 16;
      4: return 32'(0 - ($urandom % 16));
      default: return $urandom;
    endcase
  endfunction

  typedef struct { logic [1:0] op; logic [31:0] a, b, r; } vec_t;
  vec_t dir[7];

  initial begin
    rst = 1'b1; i_valid = 0; i_op = 0; i_rs1_data = 0; i_rs2_data = 0; i_rd = 0;
    i_rs1_idx = 0; i_rs2_idx = 0; i_flush = 0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_rd", {27'd0, o_rd}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    chk("rst_hazard", {31'd0, o_hazard}, 32'd0);
    chk("rst_inflight", {28'd0, o_inflight}, 32'd0);

    // Directed corner vectors with hand-derived answers
    dir[0] = '{2'b00, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    dir[1] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    dir[2] = '{2'b01, 32'd100,      32'd0,        32'hFFFFFFFF};
    dir[3] = '{2'b11, 32'h1234,     32'd0,        32'h1234};
    dir[4] = '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9};
    dir[5] = '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    dir[6] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0};
    for (int i = 0; i < 7; i++)
      issue(1'b1, dir[i].op, dir[i].a, dir[i].b, 5'(10 + i), 5'd0, 5'd0, 1'b0,
            {1'b1, dir[i].r});
    drain();

    // Back-to-back: rd 1..8, full occupancy, eight consecutive retirements
    for (int k = 1; k <= 8; k++)
      issue(1'b1, 2'($urandom), pick(), pick(), 5'(k), 5'd0, 5'd0, 1'b0, 33'd0);
    idle();
    chk("b2b_inflight_full", {28'd0, o_inflight}, 32'd8);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("b2b_valid", {31'd0, o_valid}, 32'd1);
      chk("b2b_rd_order", {27'd0, o_rd}, 32'(k));
      idle();
    end
    @(negedge clk);
    chk("b2b_valid_end", {31'd0, o_valid}, 32'd0);
    chk("b2b_inflight_empty", {28'd0, o_inflight}, 32'd0);
    drain();

    // Flush: one op retiring in the flush cycle (still reported), three
    // younger ops and a same-cycle new op dropped
    issue(1'b1, 2'b01, 32'd50, 32'd7, 5'd20, 5'd0, 5'd0, 1'b0, 33'd0);
    repeat (L - 4) idle();
    for (int k = 0; k < 3; k++)
      issue(1'b1, 2'b00, $urandom, 32'd3, 5'(21 + k), 5'd0, 5'd0, 1'b0, 33'd0);
    issue(1'b1, 2'b00, 32'd9, 32'd3, 5'd24, 5'd0, 5'd0, 1'b1, 33'd0);
    idle();
    chk("flush_inflight", {28'd0, o_inflight}, 32'd0);
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      chk("flush_no_valid", {31'd0, o_valid}, 32'd0);
      idle();
    end

    // Hazard
    issue(1'b1, 2'b00, 32'd10, 32'd2, 5'd5, 5'd0, 5'd0, 1'b0, 33'd0);
    issue(1'b1, 2'b01, 32'd10, 32'd3, 5'd6, 5'd5, 5'd0, 1'b0, 33'd0);
`ifdef DIV_HAZARD_CHECK_EN
    chk("hazard_rs1_hit", {31'd0, o_hazard}, 32'd1);
`else
    chk("hazard_disabled", {31'd0, o_hazard}, 32'd0);
`endif
    issue(1'b1, 2'b01, 32'd10, 32'd3, 5'd0, 5'd0, 5'd0, 1'b0, 33'd0);
    issue(1'b1, 2'b01, 32'd11, 32'd3, 5'd7, 5'd0, 5'd0, 1'b0, 33'd0);
    chk("hazard_x0_ignored", {31'd0, o_hazard}, 32'd0);
    drain();

    // Randomized traffic with occasional flushes
    for (int n = 0; n < 300; n++) begin
      issue(($urandom % 10) < 7, 2'($urandom), pick(), pick(), 5'($urandom),
            5'd0, 5'd0, ($urandom % 40) == 0, 33'd0);
    end
    idle();
    drain();

    // Reset mid-flight: in-flight ops vanish without o_valid
    for (int k = 0; k < 3; k++)
      issue(1'b1, 2'b01, $urandom, 32'd5, 5'(1 + k), 5'd0, 5'd0, 1'b0, 33'd0);
    idle();
    #1 rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_inflight", {28'd0, o_inflight}, 32'd0);
    chk("midrst_valid", {31'd0, o_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < L + 2; k++) begin
      @(negedge clk);
      chk("post_rst_no_valid", {31'd0, o_valid}, 32'd0);
      idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
